// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues dword-aligned data-memory requests, extends load data and
// registers writeback outputs. Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
package mem_access_pkg;
    typedef enum logic [2:0] {
        LsB  = 3'd0,
        LsH  = 3'd1,
        LsW  = 3'd2,
        LsD  = 3'd3,
        LsBU = 3'd4,
        LsHU = 3'd5,
        LsWU = 3'd6
    } load_store_variant_e;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter bit          RESP_HOLD = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [63:0]         ex_result,
    input  logic [63:0]         ex_store_data,
    input  logic                ex_is_mem,
    input  logic                ex_is_write,
    input  load_store_variant_e ex_ls_variant,
    input  logic [4:0]          ex_rd,
    input  logic                ex_write_to_rd,
    input  logic                ex_is_final,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic                dmem_we,
    output logic [7:0]          dmem_wstrb,
    output logic [63:0]         dmem_wdata,
    input  logic                dmem_resp_valid,
    input  logic [63:0]         dmem_rdata,
    output logic                wb_valid_q,
    output logic [4:0]          wb_rd_q,
    output logic [63:0]         wb_data_q,
    output logic                wb_write_to_rd_q,
    output logic                wb_is_final_q,
    output logic                misalign_fault,
    input  logic                stall_in,
    output logic                stall_out
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e              state_q, state_d;
    logic [63:0]         cap_addr_q, cap_addr_d;
    logic [63:0]         cap_data_q, cap_data_d;
    load_store_variant_e cap_var_q, cap_var_d;
    logic [4:0]          cap_rd_q, cap_rd_d;
    logic                cap_wtr_q, cap_wtr_d;
    logic                cap_final_q, cap_final_d;
    logic                cap_we_q, cap_we_d;
    logic                cap_mis_q, cap_mis_d;
    logic [63:0]         hold_q, hold_d;

    logic                wb_valid_d;
    logic [4:0]          wb_rd_d;
    logic [63:0]         wb_data_d;
    logic                wb_write_to_rd_d;
    logic                wb_is_final_d;

    logic [2:0]          ex_mask;
    logic                ex_misaligned;
    logic [63:0]         ex_addr_aligned;
    logic [2:0]          lane;
    logic [7:0]          strb_base;
    logic [63:0]         rshift;
    logic [63:0]         load_ext;

    function automatic logic [2:0] size_mask(input load_store_variant_e v);
        logic [2:0] m;
        case (v)
            LsB, LsBU: m = 3'b000;
            LsH, LsHU: m = 3'b001;
            LsW, LsWU: m = 3'b011;
            default:   m = 3'b111;
        endcase
        return m;
    endfunction

    assign ex_mask         = size_mask(ex_ls_variant);
    assign ex_misaligned   = |(ex_result[2:0] & ex_mask);
    assign ex_addr_aligned = {ex_result[63:3], ex_result[2:0] & ~ex_mask};

    assign lane   = cap_addr_q[2:0];
    assign rshift = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        strb_base = 8'hFF;
        case (cap_var_q)
            LsB, LsBU: strb_base = 8'h01;
            LsH, LsHU: strb_base = 8'h03;
            LsW, LsWU: strb_base = 8'h0F;
            default:   strb_base = 8'hFF;
        endcase
    end

    always_comb begin
        load_ext = rshift;
        case (cap_var_q)
            LsB:     load_ext = {{56{rshift[7]}}, rshift[7:0]};
            LsH:     load_ext = {{48{rshift[15]}}, rshift[15:0]};
            LsW:     load_ext = {{32{rshift[31]}}, rshift[31:0]};
            LsBU:    load_ext = {56'd0, rshift[7:0]};
            LsHU:    load_ext = {48'd0, rshift[15:0]};
            LsWU:    load_ext = {32'd0, rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

    // Request fields are only driven while the request is live so reset leaves them all zero.
    assign dmem_req_valid = (state_q == StReq);
    assign dmem_addr      = dmem_req_valid ? {cap_addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign dmem_we        = dmem_req_valid & cap_we_q;
    assign dmem_wstrb     = dmem_req_valid ? (strb_base << lane) : 8'h00;
    assign dmem_wdata     = dmem_req_valid ? (cap_data_q << {lane, 3'b000}) : 64'd0;

    assign stall_out = stall_in | (state_q != StIdle) | (ex_valid & ex_is_mem);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign_fault = misalign_q;
`else
    assign misalign_fault = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        cap_addr_d       = cap_addr_q;
        cap_data_d       = cap_data_q;
        cap_var_d        = cap_var_q;
        cap_rd_d         = cap_rd_q;
        cap_wtr_d        = cap_wtr_q;
        cap_final_d      = cap_final_q;
        cap_we_d         = cap_we_q;
        cap_mis_d        = cap_mis_q;
        hold_d           = hold_q;
        // Writeback holds under stall, otherwise defaults to a bubble.
        wb_valid_d       = stall_in ? wb_valid_q : 1'b0;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        wb_write_to_rd_d = wb_write_to_rd_q;
        wb_is_final_d    = wb_is_final_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d       = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (ex_valid && ex_is_mem) begin
                    cap_addr_d  = ex_addr_aligned;
                    cap_data_d  = ex_store_data;
                    cap_var_d   = ex_ls_variant;
                    cap_rd_d    = ex_rd;
                    cap_wtr_d   = ex_write_to_rd;
                    cap_final_d = ex_is_final;
                    cap_we_d    = ex_is_write;
`ifdef MEM_MISALIGN_TRAP_EN
                    cap_mis_d   = ex_misaligned;
                    if (!stall_in) begin
                        if (ex_misaligned) begin
                            state_d    = StDone;
                            misalign_d = 1'b1;
                        end else begin
                            state_d = StReq;
                        end
                    end
`else
                    cap_mis_d   = 1'b0;
                    if (!stall_in) begin
                        state_d = StReq;
                    end
`endif
                end else if (ex_valid && !stall_in) begin
                    wb_valid_d       = 1'b1;
                    wb_rd_d          = ex_rd;
                    wb_data_d        = ex_result;
                    wb_write_to_rd_d = ex_write_to_rd;
                    wb_is_final_d    = ex_is_final;
                end
            end
            StReq: begin
                if (dmem_req_ready) begin
                    state_d = cap_we_q ? StDone : StResp;
                end
            end
            StResp: begin
                if (dmem_resp_valid) begin
                    if (RESP_HOLD) begin
                        hold_d  = load_ext;
                        state_d = StDone;
                    end else begin
                        // No hold register: the response is guaranteed not to arrive under stall.
                        wb_valid_d       = 1'b1;
                        wb_rd_d          = cap_rd_q;
                        wb_data_d        = load_ext;
                        wb_write_to_rd_d = cap_wtr_q;
                        wb_is_final_d    = cap_final_q;
                        state_d          = StIdle;
                    end
                end
            end
            StDone: begin
                if (!stall_in) begin
                    wb_valid_d       = 1'b1;
                    wb_rd_d          = cap_rd_q;
                    wb_data_d        = (!cap_we_q && !cap_mis_q) ? hold_q : 64'd0;
                    wb_write_to_rd_d = cap_wtr_q & !cap_we_q & !cap_mis_q;
                    wb_is_final_d    = cap_final_q;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            cap_addr_q       <= 64'd0;
            cap_data_q       <= 64'd0;
            cap_var_q        <= LsB;
            cap_rd_q         <= 5'd0;
            cap_wtr_q        <= 1'b0;
            cap_final_q      <= 1'b0;
            cap_we_q         <= 1'b0;
            cap_mis_q        <= 1'b0;
            hold_q           <= 64'd0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_data_q        <= 64'd0;
            wb_write_to_rd_q <= 1'b0;
            wb_is_final_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cap_addr_q       <= cap_addr_d;
            cap_data_q       <= cap_data_d;
            cap_var_q        <= cap_var_d;
            cap_rd_q         <= cap_rd_d;
            cap_wtr_q        <= cap_wtr_d;
            cap_final_q      <= cap_final_d;
            cap_we_q         <= cap_we_d;
            cap_mis_q        <= cap_mis_d;
            hold_q           <= hold_d;
            wb_valid_q       <= wb_valid_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            wb_write_to_rd_q <= wb_write_to_rd_d;
            wb_is_final_q    <= wb_is_final_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; inputs change and outputs are sampled on negedge.
module tb_mem_access;
    import mem_access_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ex_valid;
    logic [63:0]         ex_result;
    logic [63:0]         ex_store_data;
    logic                ex_is_mem;
    logic                ex_is_write;
    load_store_variant_e ex_ls_variant;
    logic [4:0]          ex_rd;
    logic                ex_write_to_rd;
    logic                ex_is_final;
    logic                dmem_req_valid;
    logic                dmem_req_ready;
    logic [63:0]         dmem_addr;
    logic                dmem_we;
    logic [7:0]          dmem_wstrb;
    logic [63:0]         dmem_wdata;
    logic                dmem_resp_valid;
    logic [63:0]         dmem_rdata;
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic [63:0]         wb_data_q;
    logic                wb_write_to_rd_q;
    logic                wb_is_final_q;
    logic                misalign_fault;
    logic                stall_in;
    logic                stall_out;

    int checks = 0;
    int errors = 0;

    mem_access u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_store_data    (ex_store_data),
        .ex_is_mem        (ex_is_mem),
        .ex_is_write      (ex_is_write),
        .ex_ls_variant    (ex_ls_variant),
        .ex_rd            (ex_rd),
        .ex_write_to_rd   (ex_write_to_rd),
        .ex_is_final      (ex_is_final),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_addr        (dmem_addr),
        .dmem_we          (dmem_we),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_wdata       (dmem_wdata),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_rdata       (dmem_rdata),
        .wb_valid_q       (wb_valid_q),
        .wb_rd_q          (wb_rd_q),
        .wb_data_q        (wb_data_q),
        .wb_write_to_rd_q (wb_write_to_rd_q),
        .wb_is_final_q    (wb_is_final_q),
        .misalign_fault   (misalign_fault),
        .stall_in         (stall_in),
        .stall_out        (stall_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_ex();
        ex_valid       = 1'b0;
        ex_is_mem      = 1'b0;
        ex_is_write    = 1'b0;
        ex_result      = 64'd0;
        ex_store_data  = 64'd0;
        ex_rd          = 5'd0;
        ex_write_to_rd = 1'b0;
        ex_is_final    = 1'b0;
    endtask

    task automatic drive_mem(input load_store_variant_e v, input logic [63:0] a,
                             input logic [63:0] d, input logic w, input logic [4:0] rd);
        ex_valid       = 1'b1;
        ex_is_mem      = 1'b1;
        ex_is_write    = w;
        ex_ls_variant  = v;
        ex_result      = a;
        ex_store_data  = d;
        ex_rd          = rd;
        ex_write_to_rd = 1'b1;
        ex_is_final    = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dmem_req_valid) begin
                ok = 1'b1;
                break;
            end
            nxt();
        end
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wb_valid_q) begin
                ok = 1'b1;
                break;
            end
            nxt();
        end
    endtask

    // Full load: issue, accept immediately, answer in RESP, then check writeback value.
    task automatic load_op(input string tag, input load_store_variant_e v, input logic [63:0] a,
                           input logic [63:0] rdata, input logic [63:0] exp_addr,
                           input logic [63:0] exp_data);
        bit ok;
        drive_mem(v, a, 64'd0, 1'b0, 5'd7);
        #1;
        chk({tag, "_stall_out"}, stall_out, 1);
        nxt();
        idle_ex();
        wait_req(ok);
        chk({tag, "_req_seen"}, ok, 1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_we"}, dmem_we, 0);
        nxt();
        dmem_resp_valid = 1'b1;
        dmem_rdata      = rdata;
        nxt();
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 64'd0;
        chk({tag, "_wb_pending"}, wb_valid_q, 0);
        wait_wb(ok);
        chk({tag, "_wb_seen"}, ok, 1);
        chk({tag, "_wb_data"}, wb_data_q, exp_data);
        chk({tag, "_wb_rd"}, wb_rd_q, 7);
        chk({tag, "_wb_wtr"}, wb_write_to_rd_q, 1);
    endtask

    initial begin
        bit ok;
        rst_n           = 1'b0;
        stall_in        = 1'b0;
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 64'd0;
        ex_ls_variant   = LsB;
        idle_ex();
        nxt();
        nxt();
        chk("rst_wb_valid", wb_valid_q, 0);
        chk("rst_wb_data", wb_data_q, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        chk("rst_stall_out", stall_out, 0);
        chk("rst_misalign", misalign_fault, 0);
        rst_n = 1'b1;
        nxt();

        // ADD: one-cycle passthrough, no stall
        ex_valid = 1'b1; ex_result = 64'h5; ex_rd = 5'd3; ex_write_to_rd = 1'b1;
        #1;
        chk("add_stall_out", stall_out, 0);
        nxt();
        chk("add_wb_valid", wb_valid_q, 1);
        chk("add_wb_data", wb_data_q, 64'h5);
        chk("add_wb_rd", wb_rd_q, 3);
        chk("add_wb_wtr", wb_write_to_rd_q, 1);
        chk("add_stall_out2", stall_out, 0);
        idle_ex();
        nxt();
        chk("add_bubble", wb_valid_q, 0);

        // ALU op under downstream stall: writeback holds, then proceeds
        ex_valid = 1'b1; ex_result = 64'h7; ex_rd = 5'd4; ex_write_to_rd = 1'b1;
        stall_in = 1'b1;
        #1;
        chk("stl_stall_out", stall_out, 1);
        nxt();
        chk("stl_hold_valid", wb_valid_q, 0);
        chk("stl_hold_data", wb_data_q, 64'h5);
        stall_in = 1'b0;
        nxt();
        chk("stl_wb_valid", wb_valid_q, 1);
        chk("stl_wb_data", wb_data_q, 64'h7);
        idle_ex();
        nxt();

        load_op("lb", LsB, 64'h1003, 64'h0000_0000_8000_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF80);
        load_op("lbu", LsBU, 64'h1003, 64'h0000_0000_8000_0000, 64'h1000, 64'h80);
        load_op("lh", LsH, 64'h4006, 64'hBEEF_0000_0000_0000, 64'h4000, 64'hFFFF_FFFF_FFFF_BEEF);
        load_op("lhu", LsHU, 64'h4006, 64'hBEEF_0000_0000_0000, 64'h4000, 64'hBEEF);

        // SH with memory back-pressure for three cycles
        dmem_req_ready = 1'b0;
        drive_mem(LsH, 64'h2006, 64'h1234, 1'b1, 5'd9);
        nxt();
        idle_ex();
        for (int i = 0; i < 3; i++) begin
            chk("sh_req_valid", dmem_req_valid, 1);
            chk("sh_addr", dmem_addr, 64'h2000);
            chk("sh_we", dmem_we, 1);
            chk("sh_wstrb", dmem_wstrb, 8'hC0);
            chk("sh_wdata", dmem_wdata, 64'h1234_0000_0000_0000);
            chk("sh_stall_out", stall_out, 1);
            chk("sh_wb_valid", wb_valid_q, 0);
            nxt();
        end
        dmem_req_ready = 1'b1;
        nxt();
        chk("sh_req_dropped", dmem_req_valid, 0);
        chk("sh_wb_pending", wb_valid_q, 0);
        nxt();
        chk("sh_wb_valid", wb_valid_q, 1);
        chk("sh_wb_data", wb_data_q, 0);
        chk("sh_wb_wtr", wb_write_to_rd_q, 0);
        chk("sh_wb_rd", wb_rd_q, 9);

        // LD whose response arrives while downstream is stalled
        drive_mem(LsD, 64'h3000, 64'd0, 1'b0, 5'd12);
        nxt();
        idle_ex();
        chk("ld_req_valid", dmem_req_valid, 1);
        nxt();
        stall_in        = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'hDEAD_BEEF_0000_0001;
        nxt();
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 64'd0;
        chk("ld_stall_valid0", wb_valid_q, 0);
        nxt();
        chk("ld_stall_valid1", wb_valid_q, 0);
        chk("ld_stall_out", stall_out, 1);
        stall_in = 1'b0;
        nxt();
        chk("ld_wb_valid", wb_valid_q, 1);
        chk("ld_wb_data", wb_data_q, 64'hDEAD_BEEF_0000_0001);
        chk("ld_wb_rd", wb_rd_q, 12);
        nxt();

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps without a request
        drive_mem(LsW, 64'h1002, 64'd0, 1'b0, 5'd7);
        ex_is_final = 1'b1;
        nxt();
        idle_ex();
        chk("mis_fault", misalign_fault, 1);
        chk("mis_no_req", dmem_req_valid, 0);
        nxt();
        chk("mis_fault_clr", misalign_fault, 0);
        chk("mis_wb_valid", wb_valid_q, 1);
        chk("mis_wb_wtr", wb_write_to_rd_q, 0);
        chk("mis_wb_final", wb_is_final_q, 1);
        nxt();
        chk("mis_no_req2", dmem_req_valid, 0);
        load_op("lw_ok", LsW, 64'h1004, 64'h8000_0004_0000_0000, 64'h1000,
                64'hFFFF_FFFF_8000_0004);
`else
        // Misaligned LW is forced to natural alignment
        drive_mem(LsW, 64'h1002, 64'd0, 1'b0, 5'd7);
        nxt();
        idle_ex();
        chk("lw_addr", dmem_addr, 64'h1000);
        chk("lw_wstrb", dmem_wstrb, 8'h0F);
        chk("lw_fault", misalign_fault, 0);
        nxt();
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'h1111_2222_8000_0004;
        nxt();
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 64'd0;
        wait_wb(ok);
        chk("lw_wb_seen", ok, 1);
        chk("lw_wb_data", wb_data_q, 64'hFFFF_FFFF_8000_0004);
`endif
        nxt();

        // Reset while waiting in RESP abandons the load
        drive_mem(LsD, 64'h5000, 64'd0, 1'b0, 5'd2);
        nxt();
        idle_ex();
        chk("rr_req_valid", dmem_req_valid, 1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rr_req_valid0", dmem_req_valid, 0);
        chk("rr_wb_valid0", wb_valid_q, 0);
        chk("rr_wb_data0", wb_data_q, 0);
        chk("rr_stall_out0", stall_out, 0);
        nxt();
        rst_n           = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'h1234_5678_9ABC_DEF0;
        nxt();
        dmem_resp_valid = 1'b0;
        dmem_rdata      = 64'd0;
        chk("rr_no_wb0", wb_valid_q, 0);
        nxt();
        chk("rr_no_wb1", wb_valid_q, 0);
        chk("rr_no_req", dmem_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
